// File: rtl/ts_tx_ser.sv
// Training-set transmit stage: a small FIFO of 128-bit TSs feeding a byte
// serializer with K-character flagging, a saturating TS counter and sticky overflow.
module ts_tx_ser #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ts_valid,
  input  logic [127:0]     ts,
  output logic             ts_tx_fifo_full,
  input  logic             ts_flush,
  output logic [7:0]       sym_data,
  output logic             sym_k,
  output logic             sym_first,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [CNT_W-1:0] ts_tx_cnt,
  output logic             ovf
);

  localparam logic [7:0]  COM    = 8'hBC;
  localparam logic [7:0]  PADG12 = 8'hF7;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [127:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_d;
  logic [127:0]   sreg;
  logic [3:0]     idx;
  logic           push, pop, drop, accept, last;

  assign accept = (state_q == SEND) && sym_ready;
  assign last   = accept && (idx == 4'd15);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 && !ts_flush) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last) begin
          if (count != '0 && !ts_flush) pop = 1'b1;
          else                          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on the same edge frees the head slot, so a push is accepted even at full.
  assign push = ts_valid && !ts_flush && ((count < DEPTH_C) || pop);
  assign drop = ts_valid && !ts_flush && !push;

  always_comb begin
    if (ts_flush) count_d = '0;
    else          count_d = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      ts_tx_fifo_full <= 1'b0;
      ovf             <= 1'b0;
      ts_tx_cnt       <= '0;
      sreg            <= '0;
      idx             <= '0;
    end else begin
      state_q         <= state_d;
      count           <= count_d;
      ts_tx_fifo_full <= (count_d >= DEPTH_C - 1'b1);
      if (drop) ovf <= 1'b1;
      if (ts_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        sreg <= mem[rd_ptr];
        idx  <= '0;
      end else if (accept) begin
        sreg <= {sreg[119:0], 8'h00};
        idx  <= idx + 4'd1;
      end
      if (last && ts_tx_cnt != '1) ts_tx_cnt <= ts_tx_cnt + 1'b1;
    end
  end

  always_comb begin
    sym_valid = (state_q == SEND);
    sym_data  = sym_valid ? sreg[127:120] : '0;
    sym_first = sym_valid && (idx == 4'd0);
    sym_k     = sym_valid && (((idx == 4'd0) && (sym_data == COM)) ||
                              (((idx == 4'd1) || (idx == 4'd2)) && (sym_data == PADG12)));
  end

endmodule

// File: tb/tb_ts_tx_ser.sv
// Directed bench for ts_tx_ser: handshake, back-pressure, overflow, flush,
// mid-TS reset and K-character filtering against hand-computed values.
`timescale 1ns/100ps
module tb_ts_tx_ser;

  logic         clk = 1'b0;
  logic         rst, ts_valid, ts_flush, sym_ready;
  logic [127:0] ts;
  logic         ts_tx_fifo_full, sym_k, sym_first, sym_valid, ovf;
  logic [7:0]   sym_data;
  logic [15:0]  ts_tx_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] TS1 = 128'hBCF7F7FF02004A4A4A4A4A4A4A4A4A4A;
  localparam logic [127:0] D0  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] D1  = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] D2  = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] D3  = 128'h404142434445464748494A4B4C4D4E4F;
  localparam logic [127:0] D4  = 128'h505152535455565758595A5B5C5D5E5F;
  localparam logic [127:0] TSK = 128'hBCF70033BC5566778899AABBCCDDBCF7;
  localparam logic [127:0] JNK = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  ts_tx_ser #(.DEPTH(4), .AW(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ts_valid(ts_valid), .ts(ts),
    .ts_tx_fifo_full(ts_tx_fifo_full), .ts_flush(ts_flush),
    .sym_data(sym_data), .sym_k(sym_k), .sym_first(sym_first),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .ts_tx_cnt(ts_tx_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"},  32'(ts_tx_fifo_full), 32'd0);
    chk({tag, "_valid"}, 32'(sym_valid), 32'd0);
    chk({tag, "_data"},  32'(sym_data), 32'd0);
    chk({tag, "_k"},     32'(sym_k), 32'd0);
    chk({tag, "_first"}, 32'(sym_first), 32'd0);
    chk({tag, "_cnt"},   32'(ts_tx_cnt), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
  endtask

  // Expects symbol 0 of t presented now; accepts all 16 symbols (sym_ready must be 1).
  task automatic recv_ts(input string tag, input logic [127:0] t, input logic [15:0] kmask);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_valid"}, 32'(sym_valid), 32'd1);
      chk({tag, "_data"},  32'(sym_data), 32'(t[127-8*i -: 8]));
      chk({tag, "_k"},     32'(sym_k), 32'(kmask[i]));
      chk({tag, "_first"}, 32'(sym_first), 32'(i == 0));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ts_valid = 1'b0; ts_flush = 1'b0; sym_ready = 1'b0; ts = '0;
    tick(); tick();
    chk_reset_outputs("rst_in");
    rst = 1'b0;
    tick();
    chk_reset_outputs("rst_out");

    // Basic: push edge, then pop edge, then symbol 0 valid.
    sym_ready = 1'b1; ts = TS1; ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    chk("lat_pre", 32'(sym_valid), 32'd0);
    tick();
    recv_ts("ts1", TS1, 16'h0007);
    chk("ts1_idle", 32'(sym_valid), 32'd0);
    chk("ts1_cnt",  32'(ts_tx_cnt), 32'd1);

    // Back-pressure with stalled PHY.
    sym_ready = 1'b0; ts_valid = 1'b1; ts = D0;
    tick();
    ts = D1;
    tick();
    chk("bp_valid", 32'(sym_valid), 32'd1);
    chk("bp_data0", 32'(sym_data), 32'h10);
    chk("bp_full1", 32'(ts_tx_fifo_full), 32'd0);
    ts = D2;
    tick();
    chk("bp_full2", 32'(ts_tx_fifo_full), 32'd0);
    ts = D3;
    tick();
    chk("bp_full3", 32'(ts_tx_fifo_full), 32'd1);
    ts = D4;
    tick();
    chk("bp_full4", 32'(ts_tx_fifo_full), 32'd1);
    chk("bp_ovf",   32'(ovf), 32'd0);
    chk("bp_hold",  32'(sym_data), 32'h10);

    // Overflow: two extra pushes at count 4.
    ts = JNK;
    tick();
    chk("ovf_set", 32'(ovf), 32'd1);
    tick();
    ts_valid = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_hold",   32'(sym_data), 32'h10);

    // Drain: five TSs back to back, no bubble, dropped data never appears.
    sym_ready = 1'b1;
    recv_ts("b2b0", D0, 16'h0);
    recv_ts("b2b1", D1, 16'h0);
    recv_ts("b2b2", D2, 16'h0);
    recv_ts("b2b3", D3, 16'h0);
    recv_ts("b2b4", D4, 16'h0);
    chk("b2b_idle", 32'(sym_valid), 32'd0);
    chk("b2b_cnt",  32'(ts_tx_cnt), 32'd6);
    chk("b2b_full", 32'(ts_tx_fifo_full), 32'd0);

    // Flush mid-TS with a simultaneous push.
    sym_ready = 1'b0; ts_valid = 1'b1; ts = D0;
    tick();
    ts = D1; tick();
    ts = D2; tick();
    ts = D3; tick();
    ts_valid = 1'b0;
    chk("fl_full_pre", 32'(ts_tx_fifo_full), 32'd1);
    sym_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("fl_sym5", 32'(sym_data), 32'h15);
    ts_flush = 1'b1; ts_valid = 1'b1; ts = D4;
    tick();
    ts_flush = 1'b0; ts_valid = 1'b0;
    chk("fl_full_post", 32'(ts_tx_fifo_full), 32'd0);
    for (int i = 6; i < 16; i++) begin
      chk("fl_tail_valid", 32'(sym_valid), 32'd1);
      chk("fl_tail_data",  32'(sym_data), 32'(8'h10 + i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("fl_empty", 32'(sym_valid), 32'd0);
      tick();
    end
    chk("fl_cnt", 32'(ts_tx_cnt), 32'd7);

    // Reset at symbol 9.
    ts = D4; ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("rs_sym9", 32'(sym_data), 32'h59);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rs_mid");
    rst = 1'b0;
    tick();
    chk("rs_after_valid", 32'(sym_valid), 32'd0);
    tick();
    chk("rs_no_resid", 32'(sym_valid), 32'd0);

    // K filtering: COM at idx 0 and PADG12 at idx 1 flagged; BC at idx 4/14, F7 at 15 not.
    ts = TSK; ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    tick();
    recv_ts("kflt", TSK, 16'h0003);
    chk("kflt_cnt",  32'(ts_tx_cnt), 32'd1);
    chk("kflt_idle", 32'(sym_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_tx_ser.md
Name: ts_tx_ser

Overview:
- Transmit stage directly downstream of the TS generator.
- Buffers 128-bit training sets in a small FIFO and returns FIFO back-pressure as ts_tx_fifo_full.
- Serializes each training set into 16 byte-wide symbols with a K-character flag, toward the lane PHY/encoder, under a valid/ready handshake.
- Counts completed training sets and flags overflow.

Parameters:
- DEPTH, 4: FIFO entries of 128 bits; must be a power of two and at least 2.
- AW, 2: FIFO pointer width; equals log2(DEPTH).
- CNT_W, 16: width of the transmitted-TS counter.

Ports:
- clk  in  1  system clock (1 GHz).
- rst  in  1  synchronous, active-high reset.
- ts_valid  in  1  TS push strobe from the generator. Held high while it is transmitting and sees not-full.
- ts  in  128  training set; symbol 0 is ts[127:120], symbol 15 is ts[7:0].
- ts_tx_fifo_full  out  1  back-pressure to the generator.
- ts_flush  in  1  discard all queued TSs (state change from the FSM).
- sym_data  out  8  current symbol.
- sym_k  out  1  sym_data is a K-character.
- sym_first  out  1  sym_data is symbol 0 of a TS.
- sym_valid  out  1  symbol presented.
- sym_ready  in  1  PHY accepts the symbol.
- ts_tx_cnt  out  CNT_W  number of TSs fully accepted by the PHY; saturating.
- ovf  out  1  sticky; a push was dropped because the FIFO was full.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - During and after reset: ts_tx_fifo_full=0, sym_valid=0, sym_data=0, sym_k=0, sym_first=0, ts_tx_cnt=0, ovf=0.
  - After reset the FIFO is empty and the serializer is in IDLE.
  - Reset mid-TS aborts immediately; no residual symbols are emitted.
- FIFO count and full flag:
  - count is AW+1 bits.
  - ts_tx_fifo_full = (count >= DEPTH-1), registered from the next-state count.
  - The early threshold gives one slot of headroom, because the generator's ts_valid lags full by one cycle.
- Push rules:
  - A push occurs when ts_valid && count<DEPTH && !ts_flush.
  - When ts_valid && count==DEPTH && !ts_flush, the push is dropped and ovf is set until rst.
  - Push and pop in the same cycle are legal at any count, including full; count is then unchanged.
- Flush:
  - ts_flush clears the FIFO in one cycle (pointers and count to 0) and drops any same-cycle push.
  - A TS already loaded in the serializer completes all 16 symbols; truncated ordered sets are never emitted.
  - A flush during the symbol-15 acceptance edge prevents loading the next TS.
- Serializer state IDLE:
  - sym_valid=0.
  - If count!=0 and !ts_flush: pop the head TS into a 128-bit shift register, set idx=0, go to SEND.
  - Symbol 0 is presented with sym_valid=1 in the cycle after the pop edge.
  - Minimum latency from push edge to symbol 0 valid: 2 cycles.
- Serializer state SEND:
  - sym_data = symbol[idx]; sym_first = (idx==0).
  - Outputs are held stable while sym_valid && !sym_ready.
  - idx (4 bits) advances only on acceptance (sym_valid && sym_ready).
  - On acceptance with idx==15: ts_tx_cnt increments, saturating at all ones.
  - If the FIFO is non-empty and there is no flush, the next TS is loaded on that same edge and its symbol 0 follows with no bubble.
  - Otherwise go to IDLE with sym_valid=0.
- K-character rule:
  - sym_k=1 when idx==0 and the symbol equals `COM.
  - sym_k=1 when idx is 1 or 2 and the symbol equals `PADG12.
  - All other symbols have sym_k=0, including data bytes that happen to equal 8'hBC or 8'hF7.
- Other boundaries:
  - Pointers wrap modulo DEPTH.
  - No pop from an empty FIFO.
  - ts_tx_cnt does not wrap.

Test Plan:
- Basic push and serialize:
  - Stimulus: reset, then one push of a POLL TS1 (BC F7 F7 FF 02 00 4A x10) with sym_ready=1.
  - Required: sym_valid rises 2 cycles after the push edge; 16 symbols appear in order; sym_k=1 on symbols 0-2 only; sym_first on symbol 0 only; ts_tx_cnt=1.
- Back-pressure from a stalled PHY:
  - Stimulus: DEPTH=4, ts_valid held high, sym_ready=0.
  - Required: one TS is popped into the serializer, then ts_tx_fifo_full rises when count reaches 3; the lagging push fills slot 4; ovf stays 0; sym_data is held constant.
- Overflow:
  - Stimulus: force ts_valid=1 for 2 extra cycles while count=4.
  - Required: ovf=1 and sticky; count stays 4; queued data is unchanged.
- Back-to-back TSs:
  - Stimulus: 3 TSs queued, sym_ready=1.
  - Required: 48 consecutive valid cycles with no bubble; sym_first every 16 cycles; ts_tx_cnt=3.
- Flush mid-TS:
  - Stimulus: ts_flush asserted at symbol 5 of TS A with 2 TSs queued, plus a simultaneous push.
  - Required: A finishes symbols 6-15; then sym_valid=0; count=0; ts_tx_fifo_full=0; the pushed TS is never emitted.
- Reset and K-character filtering:
  - Stimulus: assert rst at symbol 9; separately send a TS whose byte 4 = 8'hBC.
  - Required: sym_valid=0 the cycle after rst; all outputs at reset values; the 8'hBC byte at index 4 has sym_k=0.
